// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receive path.
// PS2_BREAK_DECODE_EN widens FIFO entries to {ext, brk, code}.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

`ifdef PS2_BREAK_DECODE_EN
    localparam int PS2_ENTRY_W = 10;
`else
    localparam int PS2_ENTRY_W = 8;
`endif

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Scan-code read port: FWFT head, pop request, occupancy and error flags.
// PS2_BREAK_DECODE_EN adds the rd_ext/rd_brk qualifiers.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                        rd_en;
    logic [7:0]                  rd_data;
    logic                        rd_valid;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic                        parity_err;
    logic                        frame_err;
`ifdef PS2_BREAK_DECODE_EN
    logic                        rd_ext;
    logic                        rd_brk;
`endif

    modport master (
        input  rd_en,
`ifdef PS2_BREAK_DECODE_EN
        output rd_ext,
        output rd_brk,
`endif
        output rd_data,
        output rd_valid,
        output fifo_count,
        output overflow,
        output parity_err,
        output frame_err
    );

    modport slave (
        output rd_en,
`ifdef PS2_BREAK_DECODE_EN
        input  rd_ext,
        input  rd_brk,
`endif
        input  rd_data,
        input  rd_valid,
        input  fifo_count,
        input  overflow,
        input  parity_err,
        input  frame_err
    );

endinterface

// File: rtl/ps2_sync_fifo.sv
// Circular first-word-fall-through FIFO; a push is visible at the head one cycle later, no bypass.
// Full without a same-cycle pop drops the write and sets sticky overflow; push+pop when full both succeed.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock50,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_en,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop_en && !empty;
    // A pop frees the slot the write lands in, so push is legal when full if popping.
    assign do_push = push_vld && (!full || do_pop);

    always_ff @(posedge clock50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            if (push_vld && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head_vld = !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: sync, glitch filter, frame FSM with parity/stop/timeout checks, then FIFO; push 1 cycle after stop edge.
// No backpressure to the pins: a full FIFO drops the byte (sticky overflow). PS2_BREAK_DECODE_EN folds E0/F0 prefixes into rd_ext/rd_brk.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic          clock50,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_rx_fifo_if.master rd_if
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic                   clk_s1, clk_s2;
    logic                   data_s1, data_s2;
    logic [FILTER_LEN-1:0]  filt_sr;
    logic                   filt_clk, filt_clk_q;
    logic                   fall_evt;

    ps2_state_t             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   parity_bit;
    logic [TO_W-1:0]        to_cnt;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   push_vld;
    logic [PS2_ENTRY_W-1:0] push_dat;
`ifdef PS2_BREAK_DECODE_EN
    logic                   ext_pend;
    logic                   brk_pend;
`endif

    logic                   head_vld;
    logic [PS2_ENTRY_W-1:0] head_dat;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_ovf;

    always_ff @(posedge clock50) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            filt_sr    <= '1;
            filt_clk   <= 1'b1;
            filt_clk_q <= 1'b1;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr) begin
                filt_clk <= 1'b1;
            end else if (~|filt_sr) begin
                filt_clk <= 1'b0;
            end
            filt_clk_q <= filt_clk;
        end
    end

    assign fall_evt = filt_clk_q & ~filt_clk;

    always_ff @(posedge clock50) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            to_cnt       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            push_vld     <= 1'b0;
            push_dat     <= '0;
`ifdef PS2_BREAK_DECODE_EN
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
`endif
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            push_vld     <= 1'b0;

            if (state == ST_IDLE || fall_evt) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != ST_IDLE && !fall_evt && to_cnt == TO_LAST) begin
                // Device went silent mid-frame: abandon it.
                state       <= ST_IDLE;
                to_cnt      <= '0;
                frame_err_q <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                ext_pend    <= 1'b0;
                brk_pend    <= 1'b0;
`endif
            end else if (fall_evt) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_bit <= data_s2;
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        // Parity is judged first, so a doubly-bad frame reports only parity.
                        if (!(^{shift, parity_bit})) begin
                            parity_err_q <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                            ext_pend     <= 1'b0;
                            brk_pend     <= 1'b0;
`endif
                        end else if (!data_s2) begin
                            frame_err_q <= 1'b1;
`ifdef PS2_BREAK_DECODE_EN
                            ext_pend    <= 1'b0;
                            brk_pend    <= 1'b0;
`endif
                        end else begin
`ifdef PS2_BREAK_DECODE_EN
                            if (shift == PS2_PREFIX_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shift == PS2_PREFIX_BRK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                push_vld <= 1'b1;
                                push_dat <= {ext_pend, brk_pend, shift};
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                            end
`else
                            push_vld <= 1'b1;
                            push_dat <= shift;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_sync_fifo #(
        .WIDTH (PS2_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock50  (clock50),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_en   (rd_if.rd_en),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_cnt),
        .overflow (fifo_ovf)
    );

    assign rd_if.rd_data    = head_dat[7:0];
    assign rd_if.rd_valid   = head_vld;
    assign rd_if.fifo_count = fifo_cnt;
    assign rd_if.overflow   = fifo_ovf;
    assign rd_if.parity_err = parity_err_q;
    assign rd_if.frame_err  = frame_err_q;
`ifdef PS2_BREAK_DECODE_EN
    assign rd_if.rd_ext     = head_dat[9];
    assign rd_if.rd_brk     = head_dat[8];
`endif

endmodule
